// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Holds the RV32M funct3 operation enum, the FSM state enum and
// small helpers that decode operand signedness from the operation.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } muldiv_state_e;

  // SrcA is treated as two's complement (MUL low half is sign-agnostic, so it counts as unsigned)
  function automatic logic op_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // SrcB is treated as two's complement
  function automatic logic op_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Divide-family operation (DIV, DIVU, REM, REMU)
  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply, restoring divide on one shared adder.
// Latency: Done DATA_WIDTH+1 cycles after Start; 1 cycle for divide-by-zero / signed overflow.
// Backpressure: none; Start is only honoured in IDLE and ignored while Busy.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [2:0]            MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic [W-1:0]  MIN_NEG = {1'b1, {(W-1){1'b0}}};

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q, op_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          a_neg_q, a_neg_d;   // dividend/multiplicand was negative
  logic [W-1:0]  b_q, b_d;           // raw multiplier/divisor
  logic [2*W-1:0] acc_q, acc_d;      // {hi, lo}: product, or {remainder, quotient}
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  result_q, result_d;

  // Datapath scratch
  muldiv_op_e    op_in;
  logic          b_neg, is_div, no_borrow, a_neg_in;
  logic [W-1:0]  mag_b, mag_a_in, quo, rem, fix;
  logic [W:0]    add_a, add_b;
  logic [W+1:0]  sum;
  logic [2*W-1:0] acc_step, prod;

  // One shared adder: hi += multiplier (multiply) or partial remainder - divisor (divide)
  always_comb begin
    op_in    = muldiv_op_e'(MulDivOp);
    is_div   = op_is_div(op_q);
    b_neg    = op_signed_b(op_q) && b_q[W-1];
    mag_b    = b_neg ? -b_q : b_q;
    add_a    = is_div ? acc_q[2*W-1:W-1] : {1'b0, acc_q[2*W-1:W]};
    add_b    = is_div ? ~{1'b0, mag_b} : (acc_q[0] ? {1'b0, mag_b} : '0);
    sum      = {1'b0, add_a} + {1'b0, add_b} + (W+2)'(is_div);
    // carry out of the widened subtract means partial remainder >= divisor
    no_borrow = sum[W+1];
    if (is_div)
      acc_step = {(no_borrow ? sum[W-1:0] : add_a[W-1:0]), acc_q[W-2:0], no_borrow};
    else
      acc_step = {sum[W:0], acc_q[W-1:1]};
  end

  // Sign fixup of the final magnitudes, applied as the result enters DONE
  always_comb begin
    prod = (a_neg_q ^ b_neg) ? -acc_step : acc_step;
    quo  = acc_step[W-1:0];
    rem  = acc_step[2*W-1:W];
    case (op_q)
      OP_MUL:                        fix = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix = prod[2*W-1:W];
      OP_DIV, OP_DIVU:               fix = (a_neg_q ^ b_neg) ? -quo : quo;
      default:                       fix = a_neg_q ? -rem : rem;
    endcase
  end

  // Next-state logic for the IDLE -> CALC -> DONE sequence
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_neg_d  = a_neg_q;
    b_d      = b_q;
    acc_d    = acc_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    a_neg_in = op_signed_a(op_in) && SrcA[W-1];
    mag_a_in = a_neg_in ? -SrcA : SrcA;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          op_d    = op_in;
          a_neg_d = a_neg_in;
          b_d     = SrcB;
          acc_d   = {{W{1'b0}}, mag_a_in};
          cnt_d   = '0;
          busy_d  = 1'b1;
          if (op_is_div(op_in) && (SrcB == '0)) begin
            result_d = op_in[1] ? SrcA : '1;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else if (((op_in == OP_DIV) || (op_in == OP_REM)) &&
                       (SrcA == MIN_NEG) && (SrcB == '1)) begin
            result_d = (op_in == OP_DIV) ? SrcA : '0;
            done_d   = 1'b1;
            state_d  = ST_DONE;
          end else begin
            state_d  = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        if (cnt_q == LAST) begin
          cnt_d    = '0;
          result_d = fix;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      a_neg_q  <= 1'b0;
      b_q      <= '0;
      acc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_neg_q  <= a_neg_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign Result = result_q;
  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Zero   = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M corner cases, protocol/reset checks,
// an 8-bit instance, and a random sweep against a plain-arithmetic model.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, res32;
  logic        busy32, done32, zero32;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, res8;
  logic        busy8, done8, zero8;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.DATA_WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .Start(start32), .MulDivOp(op32), .SrcA(a32), .SrcB(b32),
    .Result(res32), .Busy(busy32), .Done(done32), .Zero(zero32)
  );

  muldiv_unit #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .Start(start8), .MulDivOp(op8), .SrcA(a8), .SrcB(b8),
    .Result(res8), .Busy(busy8), .Done(done8), .Zero(zero8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // RV32M semantics from plain 32/64-bit integer arithmetic
  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (op)
      3'd0: begin p = ua * ub;           return p[31:0];  end
      3'd1: begin p = sa * sb;           return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;           return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one operation on the 32-bit unit (caller is at a falling edge) and watch 40 cycles
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cyc,
                       output int pulses, output logic z);
    res = 'x; lat = 0; busy_cyc = 0; pulses = 0; z = 1'bx;
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
    for (int k = 1; k <= 40; k++) begin
      if (busy32) busy_cyc++;
      if (done32) begin
        pulses++;
        if (lat == 0) begin
          lat = k; res = res32; z = zero32;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic directed(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int          lat, bc, pc;
    logic        z;
    run32(op, a, b, res, lat, bc, pc, z);
    check({tag, " result"}, 64'(res), 64'(exp));
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " zero"}, 64'(z), 64'(exp == 0));
    check({tag, " done pulses"}, 64'(pc), 64'd1);
  endtask

  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  op;
    int          lat, bc, pc, dcount;
    logic        z;
    logic [31:0] corner [6];

    corner[0] = 32'h0;        corner[1] = 32'h1;        corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h3;

    rst = 1'b1;
    start32 = 1'b1; op32 = 3'd0; a32 = 32'd5; b32 = 32'd5;
    start8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0;
    repeat (3) @(negedge clk);
    check("reset result", 64'(res32), 64'd0);
    check("reset busy", 64'(busy32), 64'd0);
    check("reset done", 64'(done32), 64'd0);
    check("reset zero", 64'(zero32), 64'd1);
    start32 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // MUL 7 x -3 with full timing profile
    run32(3'd0, 32'd7, 32'hFFFF_FFFD, res, lat, bc, pc, z);
    check("mul result", 64'(res), 64'hFFFF_FFEB);
    check("mul latency", 64'(lat), 64'd33);
    check("mul busy cycles", 64'(bc), 64'd33);
    check("mul done pulses", 64'(pc), 64'd1);

    directed("mulh min*min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    directed("mulhu ones", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    directed("mulhsu ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    directed("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    directed("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    directed("remu 10/3", 3'd7, 32'd10, 32'd3, 32'd1, 33);
    directed("div 6/3", 3'd4, 32'd6, 32'd3, 32'd2, 33);
    directed("rem 6/3", 3'd6, 32'd6, 32'd3, 32'd0, 33);
    directed("divu by 0", 3'd5, 32'h1234, 32'd0, 32'hFFFF_FFFF, 1);
    directed("rem by 0", 3'd6, 32'h1234, 32'd0, 32'h1234, 1);
    directed("div overflow", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem overflow", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);

    // Second Start during CALC must be ignored
    start32 = 1'b1; op32 = 3'd0; a32 = 32'd7; b32 = 32'hFFFF_FFFD;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    lat = 0; res = 'x;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        start32 = 1'b1; op32 = 3'd4; a32 = 32'd100; b32 = 32'd100;
      end else begin
        start32 = 1'b0;
      end
      if (done32 && lat == 0) begin
        lat = k; res = res32;
      end
      @(negedge clk);
    end
    check("restart ignored result", 64'(res), 64'hFFFF_FFEB);
    check("restart ignored latency", 64'(lat), 64'd33);

    // Reset mid-CALC aborts; no Done afterwards without a new Start
    start32 = 1'b1; op32 = 3'd0; a32 = 32'd9; b32 = 32'd9;
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort busy", 64'(busy32), 64'd0);
    check("abort result", 64'(res32), 64'd0);
    check("abort zero", 64'(zero32), 64'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      if (done32) dcount++;
      @(negedge clk);
    end
    check("no done after abort", 64'(dcount), 64'd0);

    // Start in the very first cycle after reset release
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    directed("start after release", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    // 8-bit instance: DIVU 0xFF / 0x10
    start8 = 1'b1; op8 = 3'd5; a8 = 8'hFF; b8 = 8'h10;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 0; res = 'x;
    for (int k = 1; k <= 16; k++) begin
      if (done8 && lat == 0) begin
        lat = k; res = {24'd0, res8};
      end
      @(negedge clk);
    end
    check("w8 divu result", 64'(res), 64'h0F);
    check("w8 divu latency", 64'(lat), 64'd9);

    // Random sweep over all operations with corner-value mixing
    for (int i = 0; i < 240; i++) begin
      op = 3'(i % 8);
      a  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      if (i % 40 == 4) begin
        a = 32'h8000_0000; b = 32'hFFFF_FFFF;
      end
      run32(op, a, b, res, lat, bc, pc, z);
      check($sformatf("sweep op%0d a=%h b=%h result", op, a, b), 64'(res), 64'(ref32(op, a, b)));
      check($sformatf("sweep op%0d latency", op), 64'(lat), 64'(ref_lat32(op, a, b)));
      check($sformatf("sweep op%0d pulses", op), 64'(pc), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
